// File: rtl/vram_pkg.sv
// Shared types and helpers for the VRAM port arbiter.
// Address layout {Y[4:0],X[6:0]}, write-enable bits, FSM states.
package vram_pkg;

    localparam int COLS_DEF       = 80;
    localparam int ROWS_DEF       = 25;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int ADDR_W = 12;
    localparam int X_W    = 7;
    localparam int Y_W    = 5;

    localparam int WE_CHR  = 0;
    localparam int WE_COLR = 1;

    typedef enum logic [1:0] {
        IDLE,
        CLRPEND,
        CLEAR
    } state_t;

    // 30-bit host write entry
    typedef struct packed {
        logic [1:0]        we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        chr;
        logic [7:0]        colr;
    } wr_entry_t;

    function automatic logic [X_W-1:0] addr_x(input logic [ADDR_W-1:0] a);
        return a[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] addr_y(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:X_W];
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                      input int cols,
                                      input int rows);
        return (int'(addr_x(a)) < cols) && (int'(addr_y(a)) < rows);
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Host write buffer: synchronous FIFO of wr_entry_t with full/empty flags.
// Ports: i_clk, i_rst (sync, high), i_push, i_pop, i_data -> o_head, o_full, o_empty.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wr_entry_t i_data,
    output wr_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wr_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_rp;
    logic [CW-1:0]  r_cnt;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port screen/colour RAM arbiter: display reads > clear fill > buffered host writes.
// Ports: i_clk, i_rst, display (i_disp_*), host (i_host_*/o_host_ready), clear (i_clr_*,
// o_clr_busy), o_range_err, RAM side (o_ram_*). Clear sequencer built only with VRAM_CLEAR_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_char,
    input  logic [7:0]        i_host_colr,
    input  logic [1:0]        i_host_we,
    input  logic              i_clr_start,
    input  logic [7:0]        i_clr_char,
    input  logic [7:0]        i_clr_colr,
    output logic              o_clr_busy,
    output logic              o_range_err,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wren_s,
    output logic              o_ram_wren_c,
    output logic [7:0]        o_ram_data_s,
    output logic [7:0]        o_ram_data_c
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_range_err;
    logic              w_full;
    logic              w_empty;
    logic              w_acc;
    logic              w_in_rng;
    logic              w_push;
    logic              w_pop;
    wr_entry_t         w_in;
    wr_entry_t         w_head;
    logic              w_clr_acc;
    logic              w_clr_wr;
    logic              w_clr_last;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [7:0]        w_fill_c;
    logic [7:0]        w_fill_a;

    assign o_host_ready = !w_full && !o_clr_busy;
    assign o_range_err  = r_range_err;
    assign w_acc        = i_host_valid && o_host_ready;
    assign w_in_rng     = in_range(i_host_addr, COLS, ROWS);
    // we==0 is silently dropped; only out-of-range raises an error
    assign w_push       = w_acc && w_in_rng && (i_host_we != 2'b00) && !i_rst;
    assign w_in         = '{we: i_host_we, addr: i_host_addr,
                            chr: i_host_char, colr: i_host_colr};

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_range_err <= 1'b0;
        else       r_range_err <= w_acc && !w_in_rng;
    end

`ifdef VRAM_CLEAR_EN
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic [7:0]     r_fill_c;
    logic [7:0]     r_fill_a;

    assign o_clr_busy = (r_state != IDLE);
    assign w_clr_acc  = i_clr_start && (r_state == IDLE);
    // display cycles stall the fill without advancing the counters
    assign w_clr_wr   = (r_state == CLEAR) && !i_disp_req;
    assign w_clr_last = (r_cx == X_W'(COLS - 1)) && (r_cy == Y_W'(ROWS - 1));
    assign w_clr_addr = {r_cy, r_cx};
    assign w_fill_c   = r_fill_c;
    assign w_fill_a   = r_fill_a;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cx     <= '0;
            r_cy     <= '0;
            r_fill_c <= '0;
            r_fill_a <= '0;
        end else begin
            if (w_clr_acc) begin
                r_fill_c <= i_clr_char;
                r_fill_a <= i_clr_colr;
            end
            if (r_state == CLRPEND) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (w_clr_wr) begin
                if (r_cx == X_W'(COLS - 1)) begin
                    r_cx <= '0;
                    r_cy <= r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
        end
    end
`else
    logic w_unused;

    assign o_clr_busy = 1'b0;
    assign w_clr_acc  = 1'b0;
    assign w_clr_wr   = 1'b0;
    assign w_clr_last = 1'b0;
    assign w_clr_addr = '0;
    assign w_fill_c   = '0;
    assign w_fill_a   = '0;
    assign w_unused   = ^{i_clr_start, i_clr_char, i_clr_colr};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and the RAM port mux; write enables are held off
    // during reset so an aborted operation never leaks a write.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        o_ram_addr   = '0;
        o_ram_wren_s = 1'b0;
        o_ram_wren_c = 1'b0;
        o_ram_data_s = '0;
        o_ram_data_c = '0;

        unique case (r_state)
            IDLE:    if (w_clr_acc) w_state_nxt = CLRPEND;
            CLRPEND: if (w_empty) w_state_nxt = CLEAR;
            CLEAR:   if (w_clr_wr && w_clr_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        if (i_disp_req) begin
            o_ram_addr = i_disp_addr;
        end else if (w_clr_wr) begin
            o_ram_addr   = w_clr_addr;
            o_ram_wren_s = !i_rst;
            o_ram_wren_c = !i_rst;
            o_ram_data_s = w_fill_c;
            o_ram_data_c = w_fill_a;
        end else if (r_state != CLEAR && !w_empty) begin
            w_pop        = !i_rst;
            o_ram_addr   = w_head.addr;
            o_ram_wren_s = w_head.we[WE_CHR] && !i_rst;
            o_ram_wren_c = w_head.we[WE_COLR] && !i_rst;
            o_ram_data_s = w_head.chr;
            o_ram_data_c = w_head.colr;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: queue/index reference model plus
// scenario tasks (reset, single write, display blocking, range, random, clear).
module tb_vram_arbiter;

    localparam int D    = 4;
    localparam int NC   = 80;
    localparam int NR   = 25;
    localparam int NCLR = NC * NR;
`ifdef VRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        disp_req   = 1'b0;
    logic [11:0] disp_addr  = '0;
    logic        host_valid = 1'b0;
    logic [11:0] host_addr  = '0;
    logic [7:0]  host_char  = '0;
    logic [7:0]  host_colr  = '0;
    logic [1:0]  host_we    = '0;
    logic        clr_start  = 1'b0;
    logic [7:0]  clr_char   = '0;
    logic [7:0]  clr_colr   = '0;
    logic        host_ready;
    logic        clr_busy;
    logic        range_err;
    logic [11:0] ram_addr;
    logic        ram_wren_s;
    logic        ram_wren_c;
    logic [7:0]  ram_data_s;
    logic [7:0]  ram_data_c;

    vram_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_disp_req   (disp_req),
        .i_disp_addr  (disp_addr),
        .i_host_valid (host_valid),
        .o_host_ready (host_ready),
        .i_host_addr  (host_addr),
        .i_host_char  (host_char),
        .i_host_colr  (host_colr),
        .i_host_we    (host_we),
        .i_clr_start  (clr_start),
        .i_clr_char   (clr_char),
        .i_clr_colr   (clr_colr),
        .o_clr_busy   (clr_busy),
        .o_range_err  (range_err),
        .o_ram_addr   (ram_addr),
        .o_ram_wren_s (ram_wren_s),
        .o_ram_wren_c (ram_wren_c),
        .o_ram_data_s (ram_data_s),
        .o_ram_data_c (ram_data_c)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int obs_wr  = 0;
    int obs_rerr = 0;

    // Reference model: pending host writes as a queue, clear as a linear index.
    typedef struct {
        logic [11:0] addr;
        logic [7:0]  ch;
        logic [7:0]  co;
        logic [1:0]  we;
    } ment_t;

    ment_t      mq[$];
    bit         m_pend = 1'b0;
    bit         m_clr  = 1'b0;
    bit         m_rerr = 1'b0;
    int         m_idx  = 0;
    logic [7:0] m_fch  = '0;
    logic [7:0] m_fco  = '0;

    always @(posedge clk) begin
        int sz0;
        bit busy0;
        bit acc;
        bit inr;
        int hx;
        int hy;
        if (rst) begin
            mq.delete();
            m_pend = 1'b0;
            m_clr  = 1'b0;
            m_rerr = 1'b0;
            m_idx  = 0;
        end else begin
            sz0   = mq.size();
            busy0 = m_pend || m_clr;
            acc   = host_valid && (sz0 < D) && !busy0;
            if (m_clr) begin
                if (!disp_req) begin
                    m_idx++;
                    if (m_idx == NCLR) m_clr = 1'b0;
                end
            end else begin
                if (!disp_req && sz0 > 0) void'(mq.pop_front());
                if (m_pend && sz0 == 0) begin
                    m_pend = 1'b0;
                    m_clr  = 1'b1;
                    m_idx  = 0;
                end
            end
            if (CLR_EN && clr_start && !busy0) begin
                m_pend = 1'b1;
                m_fch  = clr_char;
                m_fco  = clr_colr;
            end
            hx  = int'(host_addr) % 128;
            hy  = int'(host_addr) / 128;
            inr = (hx < NC) && (hy < NR);
            m_rerr = acc && !inr;
            if (acc && inr && host_we != 2'b00)
                mq.push_back('{addr: host_addr, ch: host_char,
                               co: host_colr, we: host_we});
        end
    end

    // Cycle monitor: compares the RAM port and status outputs with the model.
    always @(negedge clk) begin
        logic [11:0] ea;
        logic [7:0]  es;
        logic [7:0]  ec;
        bit          ews;
        bit          ewc;
        bit          erdy;
        ea = '0; es = '0; ec = '0; ews = 1'b0; ewc = 1'b0;
        if (rst) begin
            n_total++;
            if ({ram_wren_s, ram_wren_c} !== 2'b00)
                $display("FAIL rst_wren: got %b want 00", {ram_wren_s, ram_wren_c});
            else n_pass++;
        end else begin
            if (disp_req) begin
                ea = disp_addr;
            end else if (m_clr) begin
                ea  = 12'((m_idx / NC) * 128 + (m_idx % NC));
                ews = 1'b1; ewc = 1'b1; es = m_fch; ec = m_fco;
            end else if (mq.size() > 0) begin
                ea  = mq[0].addr;
                ews = mq[0].we[0]; ewc = mq[0].we[1];
                es  = mq[0].ch; ec = mq[0].co;
            end
            erdy = (mq.size() < D) && !(m_pend || m_clr);
            n_total++;
            if (ram_addr !== ea || ram_wren_s !== ews || ram_wren_c !== ewc)
                $display("FAIL mon_port @%0t: got addr=%h ws=%b wc=%b want addr=%h ws=%b wc=%b",
                         $time, ram_addr, ram_wren_s, ram_wren_c, ea, ews, ewc);
            else n_pass++;
            if (ews) begin
                n_total++;
                if (ram_data_s !== es)
                    $display("FAIL mon_data_s @%0t: got %h want %h", $time, ram_data_s, es);
                else n_pass++;
            end
            if (ewc) begin
                n_total++;
                if (ram_data_c !== ec)
                    $display("FAIL mon_data_c @%0t: got %h want %h", $time, ram_data_c, ec);
                else n_pass++;
            end
            n_total++;
            if (host_ready !== erdy || clr_busy !== (m_pend || m_clr) || range_err !== m_rerr)
                $display("FAIL mon_status @%0t: got rdy=%b busy=%b rerr=%b want rdy=%b busy=%b rerr=%b",
                         $time, host_ready, clr_busy, range_err, erdy, m_pend || m_clr, m_rerr);
            else n_pass++;
        end
        if (ram_wren_s || ram_wren_c) obs_wr++;
        if (range_err) obs_rerr++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({ram_wren_s, ram_wren_c} !== 2'b00)
            $display("FAIL reset_wren: got %b want 00", {ram_wren_s, ram_wren_c});
        else n_pass++;
        n_total++;
        if (ram_addr !== 12'h000) $display("FAIL reset_addr: got %h want 000", ram_addr);
        else n_pass++;
        n_total++;
        if (host_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", host_ready);
        else n_pass++;
        n_total++;
        if (clr_busy !== 1'b0 || range_err !== 1'b0)
            $display("FAIL reset_flags: got busy=%b rerr=%b want 0 0", clr_busy, range_err);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_write;
        host_valid = 1'b1; host_addr = 12'h085;
        host_char = 8'h41; host_colr = 8'h1F; host_we = 2'b11;
        tick();
        host_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({ram_wren_s, ram_wren_c} !== 2'b11 || ram_addr !== 12'h085)
            $display("FAIL single_port: got ws=%b wc=%b addr=%h want 1 1 085",
                     ram_wren_s, ram_wren_c, ram_addr);
        else n_pass++;
        n_total++;
        if (ram_data_s !== 8'h41 || ram_data_c !== 8'h1F)
            $display("FAIL single_data: got %h/%h want 41/1F", ram_data_s, ram_data_c);
        else n_pass++;
        tick();
    endtask

    task automatic test_disp_block;
        int w0;
        logic rdy;
        disp_req = 1'b1;
        w0 = obs_wr;
        for (int i = 0; i < 5; i++) begin
            disp_addr  = 12'($urandom_range(0, 4095));
            host_valid = 1'b1;
            host_addr  = 12'(($urandom_range(0, NR - 1) << 7) + $urandom_range(0, NC - 1));
            host_we    = 2'($urandom_range(1, 3));
            host_char  = 8'($urandom); host_colr = 8'($urandom);
            @(negedge clk);
            rdy = host_ready;
            if (i == 4) begin
                n_total++;
                if (rdy !== 1'b0) $display("FAIL ready_on_5th: got %b want 0", rdy);
                else n_pass++;
            end
            tick();
        end
        host_valid = 1'b0;
        n_total++;
        if (obs_wr != w0) $display("FAIL disp_no_wren: got %0d writes want 0", obs_wr - w0);
        else n_pass++;
        disp_req = 1'b0;
        w0 = obs_wr;
        repeat (4) tick();
        n_total++;
        if (obs_wr - w0 != 4) $display("FAIL drain_4: got %0d writes want 4", obs_wr - w0);
        else n_pass++;
        tick();
    endtask

    task automatic test_range;
        int w0;
        int r0;
        w0 = obs_wr; r0 = obs_rerr;
        host_valid = 1'b1; host_we = 2'b11;
        host_addr = 12'h050; tick();
        host_addr = 12'hC80; tick();
        host_addr = 12'h001; host_we = 2'b00; tick();
        host_valid = 1'b0;
        repeat (3) tick();
        n_total++;
        if (obs_rerr - r0 != 2) $display("FAIL range_pulses: got %0d want 2", obs_rerr - r0);
        else n_pass++;
        n_total++;
        if (obs_wr != w0) $display("FAIL range_no_wren: got %0d want 0", obs_wr - w0);
        else n_pass++;
    endtask

    task automatic test_random;
        int w0;
        int e_push;
        int hx;
        int hy;
        w0 = obs_wr; e_push = 0;
        for (int i = 0; i < 400; i++) begin
            disp_req   = ($urandom_range(0, 3) == 0);
            disp_addr  = 12'($urandom_range(0, 4095));
            host_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) host_addr = 12'($urandom_range(0, 4095));
            else host_addr = 12'(($urandom_range(0, NR - 1) << 7) + $urandom_range(0, NC - 1));
            host_we   = 2'($urandom_range(0, 3));
            host_char = 8'($urandom); host_colr = 8'($urandom);
            @(negedge clk);
            hx = int'(host_addr) % 128;
            hy = int'(host_addr) / 128;
            if (host_valid && host_ready && hx < NC && hy < NR && host_we != 0) e_push++;
            tick();
        end
        host_valid = 1'b0; disp_req = 1'b0;
        repeat (6) tick();
        n_total++;
        if (obs_wr - w0 != e_push)
            $display("FAIL random_total: got %0d writes want %0d", obs_wr - w0, e_push);
        else n_pass++;
    endtask

`ifdef VRAM_CLEAR_EN
    task automatic test_clear;
        int w0;
        int cyc;
        disp_req = 1'b1;
        host_valid = 1'b1; host_we = 2'b11;
        host_addr = 12'h101; host_char = 8'h61; host_colr = 8'h12; tick();
        host_addr = 12'h202; host_char = 8'h62; host_colr = 8'h34; tick();
        host_valid = 1'b0;
        clr_start = 1'b1; clr_char = 8'h20; clr_colr = 8'h07; tick();
        clr_start = 1'b0; disp_req = 1'b0;
        w0 = obs_wr; cyc = 0;
        while (clr_busy && cyc < 3000) begin tick(); cyc++; end
        n_total++;
        if (cyc >= 3000) $display("FAIL clear_timeout: got busy=%b want 0", clr_busy);
        else n_pass++;
        n_total++;
        if (obs_wr - w0 != 2 + NCLR)
            $display("FAIL clear_writes: got %0d want %0d", obs_wr - w0, 2 + NCLR);
        else n_pass++;
        tick();
    endtask

    task automatic test_clear_stall;
        int w0;
        int cyc;
        clr_start = 1'b1; clr_char = 8'($urandom); clr_colr = 8'($urandom);
        tick();
        clr_start = 1'b0;
        w0 = obs_wr; cyc = 0;
        while (clr_busy && cyc < 6000) begin
            disp_req  = cyc[1];
            disp_addr = 12'($urandom_range(0, 4095));
            clr_start = (cyc == 100);
            clr_char  = 8'($urandom);
            tick();
            cyc++;
        end
        disp_req = 1'b0; clr_start = 1'b0;
        n_total++;
        if (cyc >= 6000) $display("FAIL stall_timeout: got busy=%b want 0", clr_busy);
        else n_pass++;
        n_total++;
        if (obs_wr - w0 != NCLR)
            $display("FAIL stall_writes: got %0d want %0d", obs_wr - w0, NCLR);
        else n_pass++;
        tick();
    endtask

    task automatic test_rst_mid_clear;
        int w0;
        int cyc;
        clr_start = 1'b1; clr_char = 8'h2E; clr_colr = 8'h70;
        tick();
        clr_start = 1'b0;
        w0 = obs_wr; cyc = 0;
        while (obs_wr - w0 < 1000 && cyc < 3000) begin tick(); cyc++; end
        n_total++;
        if (obs_wr - w0 != 1000) $display("FAIL rst_reach: got %0d writes want 1000", obs_wr - w0);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({ram_wren_s, ram_wren_c} !== 2'b00)
            $display("FAIL rst_cycle_wren: got %b want 00", {ram_wren_s, ram_wren_c});
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (clr_busy !== 1'b0 || host_ready !== 1'b1 || {ram_wren_s, ram_wren_c} !== 2'b00)
            $display("FAIL rst_after: got busy=%b rdy=%b wren=%b want 0 1 00",
                     clr_busy, host_ready, {ram_wren_s, ram_wren_c});
        else n_pass++;
        tick();
    endtask
`else
    task automatic test_clear_disabled;
        int w0;
        clr_start = 1'b1; clr_char = 8'h20; clr_colr = 8'h07;
        tick();
        clr_start = 1'b0;
        w0 = obs_wr;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (clr_busy !== 1'b0) $display("FAIL clr_ignored: got busy=%b want 0", clr_busy);
            else n_pass++;
            tick();
        end
        n_total++;
        if (obs_wr != w0) $display("FAIL clr_no_wren: got %0d want 0", obs_wr - w0);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_disp_block();
        test_range();
        test_random();
`ifdef VRAM_CLEAR_EN
        test_clear();
        test_clear_stall();
        test_rst_mid_clear();
`else
        test_clear_disabled();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
